mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing one 13-bit-address, multi-cycle memory port between two requesters: instruction fetch (port 0) and data load/store (port 1).
- Sequences each access as grant, request, wait for ack, then done.
- Drives the select of the shared 13-bit address mux.
- Bounds every access with a timeout, flagging `err` when it expires.

Parameters:
- ADDR_W, 13, address width; must equal the mux width.
- DATA_W, 32, data width.
- TIMEOUT, 16, maximum cycles waiting for mem_ack before abort; must be ≥2.
- CNT_W, 5, wait-counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  ADDR_W  fetch address; held stable until if_done.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  data write enable.
- d_addr  in  ADDR_W  data address; held stable until d_done.
- d_wdata  in  DATA_W  store data.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  muxed address.
- mem_wdata  out  DATA_W  store data, driven from d_wdata.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- sel  out  1  current grant: 0 = fetch, 1 = data.
- if_done  out  1  one-cycle completion pulse to fetch.
- d_done  out  1  one-cycle completion pulse to data.
- rdata  out  DATA_W  registered read data.
- err  out  1  timeout flag, valid with the done pulse.

Behaviour:
- Reset values (asynchronous, while reset_n=0):
  - state=IDLE, sel=0, last=1 (so port 0 wins the first tie), cnt=0.
  - mem_req=0, if_done=0, d_done=0, err=0, rdata=0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If only one req is high, grant it.
  - If both are high, grant ~last.
  - On the granting edge: sel<=grant, cnt<=0, next state WAIT.
  - No req: stay in IDLE, sel holds its value.
- WAIT:
  - mem_req=1 for the whole state, combinational from state.
  - Each cycle without mem_ack: cnt<=cnt+1.
  - mem_ack=1: rdata<=mem_rdata, err<=0, go to DONE.
  - cnt==TIMEOUT-1 and mem_ack=0: err<=1, rdata held, go to DONE.
  - mem_ack in the same cycle as timeout: ack wins, err=0.
- DONE (exactly one cycle):
  - Pulse if_done or d_done according to sel.
  - rdata and err are valid in this cycle.
  - last<=sel; next state IDLE.
  - err holds until the next DONE.
- Datapath:
  - mem_addr = sel ? d_addr : if_addr.
  - mem_we = mem_req & sel & d_we; fetch never writes.
  - mem_wdata = d_wdata, always driven.
- Latency:
  - req sampled at edge k gives mem_req=1 from cycle k+1.
  - mem_ack in cycle m gives done in cycle m+1.
  - Minimum access is 3 cycles.
  - A queued requester is granted in the IDLE cycle after DONE, so back-to-back service alternates ports.
- Boundary conditions:
  - mem_ack outside WAIT is ignored.
  - req dropped mid-access: no abort; the access completes and done still pulses.
  - The requester must not re-raise req in its done cycle expecting suppression; a new req in that cycle is sampled next in IDLE.
  - Reset mid-WAIT: immediate return to IDLE, mem_req falls asynchronously, no done is issued.
  - cnt saturates; it never wraps within WAIT.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, WAIT=2'd1, DONE=2'd2.
  - PORT_IF=1'b0, PORT_D=1'b1.
  - Default ADDR_W/DATA_W.
- Sub-module: the address path instantiates the existing 13-bit 2:1 mux, mux_2x1_13, with s=sel, i0=if_addr, i1=d_addr.
- FSM, counter and grant logic stay in mem_port_arbiter.

Test Plan:
- Fetch read:
  - Stimulus: if_req=1, if_addr=13'h0A5; mem_ack one cycle after mem_req rises, mem_rdata=32'hDEADBEEF.
  - Response: sel=0, mem_addr=13'h0A5, mem_we=0, if_done pulses once, rdata=32'hDEADBEEF, err=0.
- Contention:
  - Stimulus: if_req and d_req raised together after reset; both held across two accesses, each acked after 2 cycles.
  - Response: fetch granted first (sel=0), then data (sel=1); grants alternate, neither port is starved.
- Data store:
  - Stimulus: d_req=1, d_we=1, d_addr=13'h1FFF, d_wdata=32'h12345678.
  - Response: mem_we=1 only while mem_req=1, mem_addr=13'h1FFF, d_done pulses, if_done stays 0.
- Timeout:
  - Stimulus: d_req with mem_ack never asserted, TIMEOUT=16.
  - Response: mem_req high exactly 16 cycles, d_done pulses with err=1, rdata unchanged.
  - Stimulus: ack on cycle 16.
  - Response: err=0.
- Reset mid-access:
  - Stimulus: reset_n low for 1 cycle during WAIT.
  - Response: mem_req=0 asynchronously, no done pulse; the next simultaneous request grants fetch first.
- Stray ack:
  - Stimulus: mem_ack pulsed while in IDLE.
  - Response: no done pulse, rdata unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // A tie goes to the port that was not served last.
    function automatic logic pick_port(input logic if_req, input logic d_req, input logic last);
        if (if_req && d_req) begin
            return ~last;
        end
        return d_req ? PORT_D : PORT_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status signals of the shared memory port.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              sel;
    logic              if_done;
    logic              d_done;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, sel, if_done, d_done, rdata, err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, sel, if_done, d_done, rdata, err
    );

endinterface

// File: rtl/mux_2x1_13.sv
// 13-bit 2:1 address mux shared by the fetch and data ports.
module mux_2x1_13 (
    input  logic        s,
    input  logic [12:0] i0,
    input  logic [12:0] i1,
    output logic [12:0] y
);

    assign y = s ? i1 : i0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for one multi-cycle memory port shared by fetch and data,
// with a bounded wait for the memory acknowledge.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q;
    logic              sel_q;
    logic              last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              if_done_q;
    logic              d_done_q;

    logic              req_any;
    logic              grant_d;
    logic [ADDR_W-1:0] addr_mux;

    assign req_any = bus.if_req | bus.d_req;
    assign grant_d = pick_port(bus.if_req, bus.d_req, last_q);

    mux_2x1_13 u_addr_mux (
        .s  (sel_q),
        .i0 (bus.if_addr),
        .i1 (bus.d_addr),
        .y  (addr_mux)
    );

    // mem_req follows the state directly so an asynchronous reset drops it at once.
    assign bus.mem_req   = (state_q == WAIT);
    assign bus.mem_we    = bus.mem_req & sel_q & bus.d_we;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = bus.d_wdata;
    assign bus.sel       = sel_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sel_q     <= PORT_IF;
            last_q    <= PORT_D;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        sel_q   <= grant_d;
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // An ack on the final allowed cycle still counts as success.
                    if (bus.mem_ack || (cnt_q == CNT_LAST)) begin
                        state_q   <= DONE;
                        err_q     <= ~bus.mem_ack;
                        if_done_q <= (sel_q == PORT_IF);
                        d_done_q  <= (sel_q == PORT_D);
                        if (bus.mem_ack) begin
                            rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    last_q  <= sel_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   tests = 0;
    int   fails = 0;

    // Model state: last port served and the read data the arbiter should hold.
    logic          last_m = 1'b1;
    logic [DW-1:0] rdata_m = '0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Acts as the memory for one access: waits for mem_req, acks in WAIT cycle ack_at
    // (counted from 0), and returns in the cycle after mem_req falls.
    task automatic serve(input int ack_at, input logic [DW-1:0] val,
                         output int gap, output int high, output logic sel_w,
                         output logic [AW-1:0] addr_w, output logic we_w,
                         output logic [DW-1:0] wdata_w);
        gap  = 0;
        high = 0;
        while (!bus.mem_req && gap < 40) begin
            step();
            gap++;
        end
        sel_w   = bus.sel;
        addr_w  = bus.mem_addr;
        we_w    = bus.mem_we;
        wdata_w = bus.mem_wdata;
        while (bus.mem_req && high < 40) begin
            bus.mem_ack   = (high == ack_at);
            bus.mem_rdata = (high == ack_at) ? val : DW'($urandom());
            step();
            high++;
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        bus.if_req = 0; bus.d_req = 0; bus.d_we = 0; bus.mem_ack = 0;
        bus.if_addr = '0; bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0;
        #2 reset_n = 1'b0;
        step();
        step();
        tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        tests++; if (bus.sel !== 1'b0) begin fails++; $display("FAIL reset_sel: got %b want 0", bus.sel); end
        tests++; if (bus.if_done !== 1'b0 || bus.d_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b%b want 00", bus.if_done, bus.d_done); end
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.err); end
        tests++; if (bus.rdata !== '0) begin fails++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
        reset_n = 1'b1;
        step();
        last_m = 1'b1;
        rdata_m = '0;
    endtask

    task automatic test_fetch_read();
        int gap, high; logic s; logic [AW-1:0] a; logic we; logic [DW-1:0] wd;
        bus.if_addr = 13'h0A5;
        bus.if_req  = 1'b1;
        serve(1, 32'hDEADBEEF, gap, high, s, a, we, wd);
        tests++; if (gap !== 1) begin fails++; $display("FAIL fetch_latency: got %0d want 1", gap); end
        tests++; if (s !== 1'b0) begin fails++; $display("FAIL fetch_sel: got %b want 0", s); end
        tests++; if (a !== 13'h0A5) begin fails++; $display("FAIL fetch_addr: got %h want 0a5", a); end
        tests++; if (we !== 1'b0) begin fails++; $display("FAIL fetch_we: got %b want 0", we); end
        tests++; if (high !== 2) begin fails++; $display("FAIL fetch_req_len: got %0d want 2", high); end
        tests++; if (bus.if_done !== 1'b1 || bus.d_done !== 1'b0) begin fails++; $display("FAIL fetch_done: got %b%b want 10", bus.if_done, bus.d_done); end
        tests++; if (bus.rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL fetch_rdata: got %h want deadbeef", bus.rdata); end
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL fetch_err: got %b want 0", bus.err); end
        bus.if_req = 1'b0;
        step();
        tests++; if (bus.if_done !== 1'b0) begin fails++; $display("FAIL fetch_done_pulse: got %b want 0", bus.if_done); end
        rdata_m = 32'hDEADBEEF;
        last_m  = 1'b0;
    endtask

    task automatic test_data_store();
        int gap, high; logic s; logic [AW-1:0] a; logic we; logic [DW-1:0] wd; logic [DW-1:0] v;
        v = DW'($urandom());
        bus.d_addr = 13'h1FFF; bus.d_we = 1'b1; bus.d_wdata = 32'h12345678;
        bus.d_req  = 1'b1;
        serve(2, v, gap, high, s, a, we, wd);
        tests++; if (s !== 1'b1) begin fails++; $display("FAIL store_sel: got %b want 1", s); end
        tests++; if (a !== 13'h1FFF) begin fails++; $display("FAIL store_addr: got %h want 1fff", a); end
        tests++; if (we !== 1'b1) begin fails++; $display("FAIL store_we: got %b want 1", we); end
        tests++; if (wd !== 32'h12345678) begin fails++; $display("FAIL store_wdata: got %h want 12345678", wd); end
        tests++; if (high !== 3) begin fails++; $display("FAIL store_req_len: got %0d want 3", high); end
        tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL store_we_done: got %b want 0", bus.mem_we); end
        tests++; if (bus.d_done !== 1'b1 || bus.if_done !== 1'b0) begin fails++; $display("FAIL store_done: got if=%b d=%b want if=0 d=1", bus.if_done, bus.d_done); end
        bus.d_req = 1'b0;
        step();
        tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL store_we_idle: got %b want 0", bus.mem_we); end
        bus.d_we = 1'b0;
        rdata_m = v;
        last_m  = 1'b1;
    endtask

    task automatic test_contention();
        int gap, high; logic s; logic [AW-1:0] a; logic we; logic [DW-1:0] wd; logic [DW-1:0] v;
        logic exp;
        bus.if_addr = AW'($urandom()); bus.d_addr = AW'($urandom()); bus.d_we = 1'b1;
        bus.if_req = 1'b1; bus.d_req = 1'b1;
        for (int n = 0; n < 4; n++) begin
            exp = ~last_m;
            v = DW'($urandom());
            serve(1, v, gap, high, s, a, we, wd);
            tests++; if (gap !== ((n == 0) ? 1 : 2)) begin fails++; $display("FAIL cont_gap%0d: got %0d want %0d", n, gap, (n == 0) ? 1 : 2); end
            tests++; if (s !== exp) begin fails++; $display("FAIL cont_sel%0d: got %b want %b", n, s, exp); end
            tests++; if (a !== (exp ? bus.d_addr : bus.if_addr)) begin fails++; $display("FAIL cont_addr%0d: got %h", n, a); end
            tests++; if (we !== exp) begin fails++; $display("FAIL cont_we%0d: got %b want %b", n, we, exp); end
            tests++; if (bus.if_done !== ~exp || bus.d_done !== exp) begin fails++; $display("FAIL cont_done%0d: got if=%b d=%b want sel=%b", n, bus.if_done, bus.d_done, exp); end
            tests++; if (bus.rdata !== v) begin fails++; $display("FAIL cont_rdata%0d: got %h want %h", n, bus.rdata, v); end
            rdata_m = v;
            last_m  = exp;
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int gap, high; logic s; logic [AW-1:0] a; logic we; logic [DW-1:0] wd; logic [DW-1:0] v;
        bus.d_addr = AW'($urandom()); bus.d_req = 1'b1;
        serve(1000, '0, gap, high, s, a, we, wd);
        tests++; if (high !== TO) begin fails++; $display("FAIL to_req_len: got %0d want %0d", high, TO); end
        tests++; if (bus.d_done !== 1'b1) begin fails++; $display("FAIL to_done: got %b want 1", bus.d_done); end
        tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL to_err: got %b want 1", bus.err); end
        tests++; if (bus.rdata !== rdata_m) begin fails++; $display("FAIL to_rdata: got %h want %h", bus.rdata, rdata_m); end
        bus.d_req = 1'b0;
        step();
        tests++; if (bus.err !== 1'b1 || bus.d_done !== 1'b0) begin fails++; $display("FAIL to_err_hold: got err=%b done=%b want err=1 done=0", bus.err, bus.d_done); end
        v = DW'($urandom());
        bus.d_req = 1'b1;
        serve(TO - 1, v, gap, high, s, a, we, wd);
        tests++; if (high !== TO) begin fails++; $display("FAIL to_ack_len: got %0d want %0d", high, TO); end
        tests++; if (bus.err !== 1'b0 || bus.d_done !== 1'b1) begin fails++; $display("FAIL to_ack_err: got err=%b done=%b want err=0 done=1", bus.err, bus.d_done); end
        tests++; if (bus.rdata !== v) begin fails++; $display("FAIL to_ack_rdata: got %h want %h", bus.rdata, v); end
        bus.d_req = 1'b0;
        step();
        rdata_m = v;
        last_m  = 1'b1;
    endtask

    task automatic test_drop_midway();
        int gap, high; logic s; logic [AW-1:0] a; logic we; logic [DW-1:0] wd; logic [DW-1:0] v;
        v = DW'($urandom());
        bus.if_addr = AW'($urandom()); bus.if_req = 1'b1;
        step();
        bus.if_req = 1'b0;
        serve(3, v, gap, high, s, a, we, wd);
        tests++; if (high !== 4) begin fails++; $display("FAIL drop_req_len: got %0d want 4", high); end
        tests++; if (bus.if_done !== 1'b1) begin fails++; $display("FAIL drop_done: got %b want 1", bus.if_done); end
        tests++; if (bus.rdata !== v) begin fails++; $display("FAIL drop_rdata: got %h want %h", bus.rdata, v); end
        step();
        rdata_m = v;
        last_m  = 1'b0;
    endtask

    task automatic test_stray_ack();
        bus.mem_ack = 1'b1; bus.mem_rdata = ~rdata_m;
        step();
        bus.mem_ack = 1'b0;
        for (int n = 0; n < 2; n++) begin
            tests++; if (bus.if_done !== 1'b0 || bus.d_done !== 1'b0) begin fails++; $display("FAIL stray_done%0d: got if=%b d=%b want 00", n, bus.if_done, bus.d_done); end
            tests++; if (bus.rdata !== rdata_m) begin fails++; $display("FAIL stray_rdata%0d: got %h want %h", n, bus.rdata, rdata_m); end
            tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL stray_req%0d: got %b want 0", n, bus.mem_req); end
            step();
        end
    endtask

    task automatic test_reset_mid_access();
        int gap, high; logic s; logic [AW-1:0] a; logic we; logic [DW-1:0] wd; logic [DW-1:0] v;
        bus.d_addr = AW'($urandom()); bus.d_req = 1'b1;
        step();
        step();
        tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL rst_mid_pre: got %b want 1", bus.mem_req); end
        reset_n = 1'b0;
        #1;
        tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL rst_mid_async: got %b want 0", bus.mem_req); end
        bus.d_req = 1'b0;
        step();
        reset_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tests++; if (bus.if_done !== 1'b0 || bus.d_done !== 1'b0) begin fails++; $display("FAIL rst_mid_done%0d: got if=%b d=%b want 00", n, bus.if_done, bus.d_done); end
            step();
        end
        last_m = 1'b1; rdata_m = '0;
        v = DW'($urandom());
        bus.if_addr = AW'($urandom()); bus.if_req = 1'b1; bus.d_req = 1'b1;
        serve(0, v, gap, high, s, a, we, wd);
        tests++; if (s !== 1'b0) begin fails++; $display("FAIL rst_mid_first: got %b want 0", s); end
        tests++; if (bus.if_done !== 1'b1) begin fails++; $display("FAIL rst_mid_if_done: got %b want 1", bus.if_done); end
        bus.if_req = 1'b0;
        serve(0, v, gap, high, s, a, we, wd);
        tests++; if (s !== 1'b1 || gap !== 2) begin fails++; $display("FAIL rst_mid_second: got sel=%b gap=%0d want sel=1 gap=2", s, gap); end
        bus.d_req = 1'b0;
        step();
        rdata_m = v;
        last_m  = 1'b1;
    endtask

    task automatic test_random();
        int gap, high, ack_at, exp_high;
        logic s; logic [AW-1:0] a; logic we; logic [DW-1:0] wd; logic [DW-1:0] v;
        logic pend_if, pend_d, exp, exp_err;
        pend_if = 1'b0; pend_d = 1'b0;
        for (int it = 0; it < 60; it++) begin
            if (!pend_if && $urandom_range(1) == 1) begin
                pend_if = 1'b1; bus.if_addr = AW'($urandom()); bus.if_req = 1'b1;
            end
            if (!pend_d && $urandom_range(1) == 1) begin
                pend_d = 1'b1; bus.d_addr = AW'($urandom()); bus.d_we = 1'($urandom_range(1));
                bus.d_wdata = DW'($urandom()); bus.d_req = 1'b1;
            end
            if (!pend_if && !pend_d) begin
                pend_if = 1'b1; bus.if_addr = AW'($urandom()); bus.if_req = 1'b1;
            end
            exp      = (pend_if && pend_d) ? ~last_m : pend_d;
            ack_at   = $urandom_range(0, TO + 3);
            exp_err  = (ack_at >= TO);
            exp_high = exp_err ? TO : ack_at + 1;
            v        = DW'($urandom());
            serve(ack_at, v, gap, high, s, a, we, wd);
            if (!exp_err) rdata_m = v;
            tests++; if (gap !== 1) begin fails++; $display("FAIL rnd_gap%0d: got %0d want 1", it, gap); end
            tests++; if (s !== exp) begin fails++; $display("FAIL rnd_sel%0d: got %b want %b", it, s, exp); end
            tests++; if (a !== (exp ? bus.d_addr : bus.if_addr)) begin fails++; $display("FAIL rnd_addr%0d: got %h", it, a); end
            tests++; if (we !== (exp & bus.d_we)) begin fails++; $display("FAIL rnd_we%0d: got %b want %b", it, we, exp & bus.d_we); end
            tests++; if (wd !== bus.d_wdata) begin fails++; $display("FAIL rnd_wdata%0d: got %h want %h", it, wd, bus.d_wdata); end
            tests++; if (high !== exp_high) begin fails++; $display("FAIL rnd_len%0d: got %0d want %0d", it, high, exp_high); end
            tests++; if (bus.if_done !== ~exp || bus.d_done !== exp) begin fails++; $display("FAIL rnd_done%0d: got if=%b d=%b want sel=%b", it, bus.if_done, bus.d_done, exp); end
            tests++; if (bus.err !== exp_err) begin fails++; $display("FAIL rnd_err%0d: got %b want %b", it, bus.err, exp_err); end
            tests++; if (bus.rdata !== rdata_m) begin fails++; $display("FAIL rnd_rdata%0d: got %h want %h", it, bus.rdata, rdata_m); end
            last_m = exp;
            if (exp) begin pend_d = 1'b0; bus.d_req = 1'b0; end
            else begin pend_if = 1'b0; bus.if_req = 1'b0; end
            step();
            tests++; if (bus.if_done !== 1'b0 || bus.d_done !== 1'b0) begin fails++; $display("FAIL rnd_pulse%0d: got if=%b d=%b want 00", it, bus.if_done, bus.d_done); end
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_data_store();
        test_contention();
        test_timeout();
        test_drop_midway();
        test_stray_ack();
        test_reset_mid_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
